// File: rtl/key_bounce_emu.sv
// Emulated mechanical push-button: one start request yields a press/hold/release
// cycle on key_n, with LFSR-timed contact bounce on both edges.
module key_bounce_emu #(
    parameter int unsigned BOUNCE_CYCLES = 250_000,
    parameter int unsigned GLITCH_W      = 12,
    parameter logic [15:0] SEED          = 16'hACE1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [31:0] hold_cycles,
    output logic        key_n,
    output logic        busy,
    output logic        done,
    output logic [1:0]  dbg_state
);

    localparam int WIN_W = (BOUNCE_CYCLES > 0) ? $clog2(BOUNCE_CYCLES + 1) : 1;
    localparam logic [WIN_W-1:0] WIN_LAST = (BOUNCE_CYCLES > 0) ? WIN_W'(BOUNCE_CYCLES - 1) : '0;
    localparam int SEG_W = GLITCH_W + 1;
    localparam logic [15:0] SEED_EFF = (SEED == 16'h0) ? 16'hACE1 : SEED;
    localparam logic [15:0] TAPS = 16'hB400;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PRESS_B = 2'd1,
        HOLD    = 2'd2,
        REL_B   = 2'd3
    } state_t;

    state_t           state, state_nx;
    logic [WIN_W-1:0] win_cnt, win_nx;
    logic [SEG_W-1:0] seg_cnt, seg_nx, seg_load;
    logic [31:0]      hold_cnt, hold_cnt_nx;
    logic [31:0]      hold_len, hold_len_nx, hold_len_in;
    logic [15:0]      lfsr, lfsr_nx;
    logic             key_nx, busy_nx, done_nx, final_lvl;

    // start is a single-cycle request honoured only while IDLE; there is no
    // ready/ack, a request arriving while busy is simply dropped.
    assign seg_load    = {1'b0, lfsr[GLITCH_W-1:0]} + {{GLITCH_W{1'b0}}, 1'b1};
    assign hold_len_in = (hold_cycles == 32'd0) ? 32'd1 : hold_cycles;
    assign final_lvl   = (state == REL_B);
    assign dbg_state   = state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            win_cnt  <= '0;
            seg_cnt  <= '0;
            hold_cnt <= '0;
            hold_len <= '0;
            lfsr     <= SEED_EFF;
            key_n    <= 1'b1;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            state    <= state_nx;
            win_cnt  <= win_nx;
            seg_cnt  <= seg_nx;
            hold_cnt <= hold_cnt_nx;
            hold_len <= hold_len_nx;
            lfsr     <= lfsr_nx;
            key_n    <= key_nx;
            busy     <= busy_nx;
            done     <= done_nx;
        end
    end

    always_comb begin
        state_nx    = state;
        win_nx      = win_cnt;
        seg_nx      = seg_cnt;
        hold_cnt_nx = hold_cnt;
        hold_len_nx = hold_len;
        key_nx      = key_n;
        busy_nx     = busy;
        done_nx     = 1'b0;
        lfsr_nx     = busy ? ({1'b0, lfsr[15:1]} ^ (lfsr[0] ? TAPS : 16'h0)) : lfsr;

        case (state)
            IDLE: begin
                key_nx  = 1'b1;
                busy_nx = 1'b0;
                if (start) begin
                    busy_nx     = 1'b1;
                    key_nx      = 1'b0;
                    hold_len_nx = hold_len_in;
                    hold_cnt_nx = '0;
                    win_nx      = '0;
                    seg_nx      = seg_load;
                    state_nx    = (BOUNCE_CYCLES == 0) ? HOLD : PRESS_B;
                end
            end
            PRESS_B, REL_B: begin
                if (win_cnt == WIN_LAST) begin
                    if (state == PRESS_B) begin
                        state_nx    = HOLD;
                        hold_cnt_nx = '0;
                        key_nx      = 1'b0;
                    end else begin
                        state_nx = IDLE;
                        key_nx   = 1'b1;
                        busy_nx  = 1'b0;
                        done_nx  = 1'b1;
                    end
                end else begin
                    win_nx = win_cnt + 1'b1;
                    if (seg_cnt == {{GLITCH_W{1'b0}}, 1'b1}) begin
                        key_nx = ~key_n;
                        seg_nx = seg_load;
                    end else begin
                        seg_nx = seg_cnt - 1'b1;
                    end
                    // The window's last cycle settles on the target level regardless of bounce.
                    if (win_nx == WIN_LAST) key_nx = final_lvl;
                end
            end
            HOLD: begin
                key_nx = 1'b0;
                if (hold_cnt == hold_len - 32'd1) begin
                    if (BOUNCE_CYCLES == 0) begin
                        state_nx = IDLE;
                        key_nx   = 1'b1;
                        busy_nx  = 1'b0;
                        done_nx  = 1'b1;
                    end else begin
                        state_nx = REL_B;
                        win_nx   = '0;
                        seg_nx   = seg_load;
                        key_nx   = 1'b1;
                    end
                end else begin
                    hold_cnt_nx = hold_cnt + 32'd1;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

endmodule

// File: tb/tb_key_bounce_emu.sv
// Bench for key_bounce_emu: a bouncing instance (64-cycle windows) and a clean-edge
// instance, checked against hand-computed cycle tables and bounce-shape rules.
module tb_key_bounce_emu;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start_a = 1'b0, start_b = 1'b0;
    logic [31:0] hold_a = 32'd0, hold_b = 32'd0;
    logic        key_a, busy_a, done_a, key_b, busy_b, done_b;
    logic [1:0]  st_a, st_b;

    int checks = 0;
    int errors = 0;

    logic       key_tr[0:499];
    logic       busy_tr[0:499];
    logic       done_tr[0:499];
    logic [1:0] st_tr[0:499];
    logic       ref_tr[0:499];
    logic [31:0] exp_q[$];

    typedef struct {
        int         off;
        logic       key;
        logic       bsy;
        logic       dn;
        logic [1:0] st;
    } vec_t;
    vec_t t2[9];

    typedef struct {
        logic [31:0] hold;
        int          done_off;
    } bvec_t;
    bvec_t t3[4];

    key_bounce_emu #(.BOUNCE_CYCLES(64), .GLITCH_W(3), .SEED(16'hACE1)) dut_a (
        .clk(clk), .rst_n(rst_n), .start(start_a), .hold_cycles(hold_a),
        .key_n(key_a), .busy(busy_a), .done(done_a), .dbg_state(st_a)
    );

    key_bounce_emu #(.BOUNCE_CYCLES(0), .GLITCH_W(3), .SEED(16'h0)) dut_b (
        .clk(clk), .rst_n(rst_n), .start(start_b), .hold_cycles(hold_b),
        .key_n(key_b), .busy(busy_b), .done(done_b), .dbg_state(st_b)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Press on the bouncing instance; start is re-raised during cycles inj1/inj2.
    task automatic press_a(input logic [31:0] h, input int n, input int inj1, input int inj2);
        @(negedge clk);
        key_tr[0] = key_a;
        hold_a = h;
        start_a = 1'b1;
        for (int k = 1; k <= n; k++) begin
            @(negedge clk);
            key_tr[k] = key_a; busy_tr[k] = busy_a; done_tr[k] = done_a; st_tr[k] = st_a;
            start_a = (k == inj1) || (k == inj2);
            hold_a = 32'd7;
        end
        start_a = 1'b0;
    endtask

    task automatic press_b(input logic [31:0] h, input int n);
        @(negedge clk);
        key_tr[0] = key_b;
        hold_b = h;
        start_b = 1'b1;
        for (int k = 1; k <= n; k++) begin
            @(negedge clk);
            key_tr[k] = key_b; busy_tr[k] = busy_b; done_tr[k] = done_b; st_tr[k] = st_b;
            start_b = 1'b0;
            hold_b = 32'd9;
        end
    endtask

    task automatic apply_t2(input string tag);
        for (int i = 0; i < 9; i++) begin
            chk($sformatf("%s_key@%0d", tag, t2[i].off), 32'(key_tr[t2[i].off]), 32'(t2[i].key));
            chk($sformatf("%s_busy@%0d", tag, t2[i].off), 32'(busy_tr[t2[i].off]), 32'(t2[i].bsy));
            chk($sformatf("%s_done@%0d", tag, t2[i].off), 32'(done_tr[t2[i].off]), 32'(t2[i].dn));
            chk($sformatf("%s_state@%0d", tag, t2[i].off), 32'(st_tr[t2[i].off]), 32'(t2[i].st));
        end
    endtask

    // Completed runs inside a bounce window must be 1..8 cycles, and the line must move.
    task automatic check_bounce(input string tag, input int lo, input int hi);
        int edges, bad, run_start;
        edges = 0; bad = 0; run_start = lo;
        for (int k = lo + 1; k <= hi; k++) begin
            if (key_tr[k] !== key_tr[k-1]) begin
                edges++;
                if ((k - run_start) < 1 || (k - run_start) > 8) bad++;
                run_start = k;
            end
        end
        chk({tag, "_bad_runs"}, 32'(bad), 32'd0);
        chk({tag, "_has_edges"}, 32'(edges > 0), 32'd1);
    endtask

    task automatic check_test2(input string tag);
        int bad_hold, bad_busy, n_done;
        bad_hold = 0; bad_busy = 0; n_done = 0;
        apply_t2(tag);
        for (int k = 65; k <= 164; k++) if (key_tr[k] !== 1'b0) bad_hold++;
        for (int k = 1; k <= 228; k++) if (busy_tr[k] !== 1'b1) bad_busy++;
        for (int k = 1; k <= 230; k++) if (done_tr[k] === 1'b1) n_done++;
        chk({tag, "_hold_low"}, 32'(bad_hold), 32'd0);
        chk({tag, "_busy_span"}, 32'(bad_busy), 32'd0);
        chk({tag, "_done_count"}, 32'(n_done), 32'd1);
        check_bounce({tag, "_press"}, 1, 64);
        check_bounce({tag, "_rel"}, 165, 228);
    endtask

    initial begin
        int got, edges, n_done;

        t2[0] = '{1,   1'b0, 1'b1, 1'b0, 2'd1};
        t2[1] = '{64,  1'b0, 1'b1, 1'b0, 2'd1};
        t2[2] = '{65,  1'b0, 1'b1, 1'b0, 2'd2};
        t2[3] = '{164, 1'b0, 1'b1, 1'b0, 2'd2};
        t2[4] = '{165, 1'b1, 1'b1, 1'b0, 2'd3};
        t2[5] = '{228, 1'b1, 1'b1, 1'b0, 2'd3};
        t2[6] = '{229, 1'b1, 1'b0, 1'b1, 2'd0};
        t2[7] = '{230, 1'b1, 1'b0, 1'b0, 2'd0};
        t2[8] = '{100, 1'b0, 1'b1, 1'b0, 2'd2};
        t3[0] = '{32'd0, 2};
        t3[1] = '{32'd1, 2};
        t3[2] = '{32'd3, 4};
        t3[3] = '{32'd5, 6};

        // Reset held, then quiet idle with no start.
        repeat (5) @(negedge clk);
        chk("rst_outputs", {29'd0, key_a, busy_a, done_a}, 32'h4);
        chk("rst_state", 32'(st_a), 32'd0);
        rst_n = 1'b1;
        for (int k = 0; k < 1000; k++) begin
            @(negedge clk);
            chk("idle_quiet", {26'd0, key_a, busy_a, done_a, key_b, busy_b, done_b}, 32'h24);
        end

        // Full press with bounce, H=100.
        press_a(32'd100, 232, -1, -1);
        check_test2("press1");
        for (int k = 0; k <= 232; k++) ref_tr[k] = key_tr[k];

        // Clean-edge instance over several hold lengths.
        for (int i = 0; i < 4; i++) begin
            press_b(t3[i].hold, 8);
            edges = 0;
            for (int k = 1; k <= 8; k++) begin
                if (key_tr[k] !== key_tr[k-1]) edges++;
                chk($sformatf("clean_h%0d_key@%0d", t3[i].hold, k), 32'(key_tr[k]), 32'(k >= t3[i].done_off));
                chk($sformatf("clean_h%0d_done@%0d", t3[i].hold, k), 32'(done_tr[k]), 32'(k == t3[i].done_off));
                chk($sformatf("clean_h%0d_busy@%0d", t3[i].hold, k), 32'(busy_tr[k]), 32'(k < t3[i].done_off));
            end
            chk($sformatf("clean_h%0d_edges", t3[i].hold), 32'(edges), 32'd2);
        end

        // Start ignored while busy; start in done cycle accepted with the new hold (7).
        press_a(32'd100, 230, 50, 229);
        n_done = 0;
        for (int k = 1; k <= 228; k++) if (done_tr[k] === 1'b1) n_done++;
        chk("busy_start_no_done", 32'(n_done), 32'd0);
        chk("busy_start_state@51", 32'(st_tr[51]), 32'd1);
        chk("first_done@229", 32'(done_tr[229]), 32'd1);
        chk("b2b_key@230", 32'(key_tr[230]), 32'd0);
        chk("b2b_busy@230", 32'(busy_tr[230]), 32'd1);
        exp_q.push_back(32'd365);
        got = -1;
        for (int k = 231; k <= 600; k++) begin
            @(negedge clk);
            if (done_a === 1'b1) begin
                got = k;
                break;
            end
        end
        chk("second_done_cycle", 32'(got), exp_q.pop_front());

        // Reset in the middle of HOLD.
        repeat (3) @(negedge clk);
        press_a(32'd100, 119, -1, -1);
        chk("pre_rst_state", 32'(st_tr[119]), 32'd2);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_outputs", {29'd0, key_a, busy_a, done_a}, 32'h4);
        n_done = 0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            if (done_a === 1'b1) n_done++;
        end
        chk("rst_no_done", 32'(n_done), 32'd0);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        press_a(32'd100, 232, -1, -1);
        check_test2("press_after_rst");
        edges = 0;
        for (int k = 0; k <= 232; k++) if (key_tr[k] !== ref_tr[k]) edges++;
        chk("seed_reload_trace", 32'(edges), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
